state_receiver: RTL
===================

Name: state_receiver

Overview:
- SPI-style frame receiver on the inter-FPGA link. It deserialises one data_t player-state frame driven by the peer board's state transmitter (data, data_clk, sel).
- Presents each good frame as player_data_out with a one-cycle valid pulse, holds the last good frame, and flags malformed or stalled frames.
- Sits at the top level between the board-to-board pins and the game FSM that consumes the opponent's state.

Parameters:
- DATA_WIDTH, $bits(data_t), frame length in bits; must equal the transmitter's width.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input pin; minimum 2.
- TIMEOUT_CYCLES, 1024, maximum clk_pixel_in cycles between data_clk rising edges while selected; must exceed the transmitter's data_clk period (100) with margin.
- COUNT_WIDTH, 8, width of the good-frame counter.

Ports:
- clk_pixel_in  input  1  system pixel clock; the only clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- data_in  input  1  serial data from the peer, MSB first; asynchronous to clk_pixel_in.
- data_clk_in  input  1  serial bit clock from the peer; bits are sampled on its rising edge.
- sel_in  input  1  frame select, active low; idles high.
- player_data_out  output  DATA_WIDTH (data_t)  last good frame received.
- player_data_out_valid  output  1  one-cycle pulse when player_data_out updates.
- frame_error_out  output  1  one-cycle pulse on a bad or aborted frame.
- frames_received_out  output  COUNT_WIDTH  count of good frames; wraps.

Behaviour:
- Clock and reset: one clock (clk_pixel_in); reset is asynchronous and active-low (rst_n_in), all flops clear immediately when rst_n_in is low.
- Reset values: player_data_out=0, player_data_out_valid=0, frame_error_out=0, frames_received_out=0, shift register=0, bit count=0, state=WAIT_DESELECT.
- Input conditioning:
  - data_in, data_clk_in, sel_in each pass through SYNC_STAGES flops.
  - One more register per line holds the previous synchronised value for edge detection.
  - sclk_rise = synchronised data_clk is 1 and was 0 last cycle. sel_fall and sel_rise are defined the same way on synchronised sel.
  - Synchronisers reset to 0 for data and data_clk, and to 1 for sel.
- State WAIT_DESELECT: ignore all activity until synchronised sel is 1, then go to IDLE. This discards a frame that is already in progress at reset release or after an abort.
- State IDLE: on sel_fall, clear bit count, overrun flag and timeout counter, then go to SHIFT. data_clk edges seen in IDLE are ignored.
- State SHIFT:
  - On sclk_rise with count < DATA_WIDTH: shift_reg <= {shift_reg[DATA_WIDTH-2:0], data_s}, count++.
  - On sclk_rise with count == DATA_WIDTH: set the overrun flag; the shift register is unchanged.
  - The timeout counter clears on every sclk_rise and otherwise increments.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no sel_rise: pulse frame_error_out and go to WAIT_DESELECT.
  - On sel_rise:
    - If count == DATA_WIDTH and no overrun: player_data_out <= shift_reg, pulse player_data_out_valid, frames_received_out++ (wraps modulo 2^COUNT_WIDTH).
    - Otherwise (short frame or overrun): pulse frame_error_out; player_data_out is unchanged.
    - Either way, return to IDLE.
- Simultaneous sclk_rise and sel_rise in the same cycle: the bit is shifted and counted first, and the completion check uses the updated count. A frame whose final bit coincides with deselect is therefore good.
- Latency: player_data_out_valid rises on the cycle after the cycle in which sel_rise is detected. Pin to valid is SYNC_STAGES+2 cycles.
- player_data_out_valid and frame_error_out are never high in the same cycle; each is high for exactly one cycle.
- Between frames player_data_out holds its value indefinitely.
- Bit count width is $clog2(DATA_WIDTH+1). Timeout counter width is $clog2(TIMEOUT_CYCLES); it saturates and does not wrap.

Decomposition:
- data_t stays in the shared types package (hdl/types.svh).
- Add a package constant LINK_DATA_PERIOD = 100, used by both transmitter and receiver, so TIMEOUT_CYCLES can be derived from it.
- The receiver state enum (WAIT_DESELECT, IDLE, SHIFT) is local to this module.
- One sub-module, sync_ff (parameter STAGES, RESET_VAL; asynchronous active-low reset), instantiated three times.
- Target size: roughly 150-200 lines of RTL.

Test Plan:
- Good frame: send a DATA_WIDTH frame of alternating 1010…, MSB first, data_clk period 100, then deselect -> single valid pulse, player_data_out = 0xAAAA… (DATA_WIDTH bits), frames_received_out = 1, no error.
- Short frame: DATA_WIDTH-1 bits then deselect -> frame_error_out pulses once, no valid, player_data_out keeps the previous value, frames_received_out unchanged.
- Overrun: DATA_WIDTH+3 bits then deselect -> one frame_error_out pulse, no valid; a following good frame with all-ones data is accepted normally.
- Stall: drop sel, send 5 bits, then hold data_clk for 1100 cycles -> frame_error_out at cycle 1023 after the last edge; a later good frame is accepted only after sel returns high.
- Reset mid-frame: pull rst_n_in low during bit 10, release with sel still low, finish that frame -> no valid and no error; the next full frame is valid; all outputs read 0 while reset is held.
- Counter wrap and back-to-back traffic: 256 good frames with a 5-cycle sel-high gap -> 256 valid pulses, frames_received_out wraps to 0, and the last payload matches what was sent.

Source files
------------

// File: rtl/state_receiver_pkg.sv
// state_receiver_pkg: shared types and constants for the inter-FPGA state link.
//   data_t              - player-state frame carried over the link
//   LINK_DATA_PERIOD    - transmitter data_clk period in pixel-clock cycles
//   LINK_TIMEOUT_CYCLES - receiver stall limit, derived from LINK_DATA_PERIOD
package state_receiver_pkg;

    typedef logic [15:0] data_t;

    localparam int unsigned LINK_DATA_PERIOD = 100;

    // Roughly 8x the bit period, rounded up to a power of two so the
    // receiver's saturating timeout counter uses its full range.
    localparam int unsigned LINK_TIMEOUT_CYCLES = 2 ** $clog2(LINK_DATA_PERIOD * 8);

endpackage

// File: rtl/state_receiver_if.sv
// state_receiver_if: board-to-board link pins plus the receiver's frame outputs.
//   master : peer / consumer side (drives the pins, observes the frame outputs)
//   slave  : state_receiver side
interface state_receiver_if
    import state_receiver_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                   data_in;
    logic                   data_clk_in;
    logic                   sel_in;
    data_t                  player_data_out;
    logic                   player_data_out_valid;
    logic                   frame_error_out;
    logic [COUNT_WIDTH-1:0] frames_received_out;

    modport master (
        output data_in, data_clk_in, sel_in,
        input  player_data_out, player_data_out_valid, frame_error_out, frames_received_out
    );

    modport slave (
        input  data_in, data_clk_in, sel_in,
        output player_data_out, player_data_out_valid, frame_error_out, frames_received_out
    );
endinterface

// File: rtl/state_receiver_sync_ff.sv
// sync_ff: multi-stage synchroniser for one asynchronous input.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   d_i           : asynchronous input
//   q_o           : synchronised output (STAGES cycles of latency)
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/state_receiver.sv
// state_receiver: SPI-style receiver for one data_t frame from the peer board.
//   clk_pixel_in : pixel clock (only clock)
//   rst_n_in     : asynchronous active-low reset
//   link         : pins (data, data_clk, sel active low) and frame outputs
//                  (player_data_out, valid pulse, error pulse, good-frame count)
module state_receiver
    import state_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = $bits(data_t),
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = LINK_TIMEOUT_CYCLES,
    parameter int unsigned COUNT_WIDTH    = 8
) (
    input  logic             clk_pixel_in,
    input  logic             rst_n_in,
    state_receiver_if.slave  link
);
    localparam int unsigned CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(DATA_WIDTH);
    localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    localparam logic [1:0] ST_WAIT_DESELECT = 2'd0;
    localparam logic [1:0] ST_IDLE          = 2'd1;
    localparam logic [1:0] ST_SHIFT         = 2'd2;

    logic data_s, sclk_s, sel_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
        .clk_i (clk_pixel_in), .rst_ni(rst_n_in), .d_i(link.data_in), .q_o(data_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i (clk_pixel_in), .rst_ni(rst_n_in), .d_i(link.data_clk_in), .q_o(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
        .clk_i (clk_pixel_in), .rst_ni(rst_n_in), .d_i(link.sel_in), .q_o(sel_s)
    );

    logic                   sclk_prev_q, sel_prev_q;
    logic [1:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovr_q, ovr_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [DATA_WIDTH-1:0]  pdata_q, pdata_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] frames_q, frames_d;

    logic sclk_rise, sel_fall, sel_rise;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sel_fall  = ~sel_s & sel_prev_q;
    assign sel_rise  = sel_s & ~sel_prev_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;
        pdata_d  = pdata_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        frames_d = frames_q;
        // The sel synchroniser resets high, so a sel held low across reset
        // release only becomes visible after the chain flushes; hold off the
        // deselect check until then so that frame is discarded too.
        settle_d = (settle_q != SETTLE_DONE) ? settle_q + 1'b1 : settle_q;

        case (state_q)
            ST_WAIT_DESELECT: begin
                if (settle_q == SETTLE_DONE && sel_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (sel_fall) begin
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    tmo_d = '0;
                    if (cnt_q != CNT_FULL) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], data_s};
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + 1'b1;
                end
                // Completion uses this cycle's shift so a last bit arriving
                // together with deselect still completes the frame.
                if (sel_rise) begin
                    if (cnt_d == CNT_FULL && !ovr_d) begin
                        pdata_d  = shift_d;
                        valid_d  = 1'b1;
                        frames_d = frames_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_DESELECT;
                end
            end
            default: state_d = ST_WAIT_DESELECT;
        endcase
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sclk_prev_q <= 1'b0;
            sel_prev_q  <= 1'b1;
            state_q     <= ST_WAIT_DESELECT;
            shift_q     <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            tmo_q       <= '0;
            settle_q    <= '0;
            pdata_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            sclk_prev_q <= sclk_s;
            sel_prev_q  <= sel_s;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
            settle_q    <= settle_d;
            pdata_q     <= pdata_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
        end
    end

    assign link.player_data_out       = pdata_q;
    assign link.player_data_out_valid = valid_q;
    assign link.frame_error_out       = err_q;
    assign link.frames_received_out   = frames_q;
endmodule
